// File: rtl/sfx_scheduler.sv
// Two-voice sound-effect scheduler: fixed-priority arbitration of NREQ requesters
// onto two timed voices, with retrigger, free-voice allocation and priority preemption.

module sfx_voice #(
  parameter int LENW = 12,
  parameter int OW   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            strobe_i,
  input  logic            load_i,
  input  logic [OW-1:0]   owner_i,
  input  logic [LENW-1:0] len_i,
  output logic            busy_o,
  output logic [OW-1:0]   owner_o,
  output logic            busy_nxt_o,
  output logic [OW-1:0]   owner_nxt_o,
  output logic            expire_o
);
  logic            busy_q, busy_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [LENW-1:0] rem_q, rem_d;

  // A load at the expiry edge takes precedence, so that voice never reports done.
  always_comb begin
    busy_d   = busy_q;
    owner_d  = owner_q;
    rem_d    = rem_q;
    expire_o = 1'b0;
    if (load_i) begin
      busy_d  = 1'b1;
      owner_d = owner_i;
      rem_d   = len_i;
    end else if (busy_q && strobe_i) begin
      if (rem_q == LENW'(1)) begin
        busy_d   = 1'b0;
        owner_d  = '0;
        rem_d    = '0;
        expire_o = 1'b1;
      end else begin
        rem_d = rem_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      owner_q <= '0;
      rem_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      rem_q   <= rem_d;
    end
  end

  assign busy_o      = busy_q;
  assign owner_o     = owner_q;
  assign busy_nxt_o  = busy_d;
  assign owner_nxt_o = owner_d;
endmodule

module sfx_scheduler #(
  parameter int NREQ = 4,
  parameter int LENW = 12,
  localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_strobe,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LENW-1:0] req_len,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic [1:0]           voice_active,
  output logic [2*OW-1:0]      voice_owner,
  output logic [NREQ-1:0]      control
);
  localparam int NV = 2;

  logic [NV-1:0]          v_busy, v_busy_nxt, v_expire, v_load;
  logic [NV-1:0][OW-1:0]  v_owner, v_owner_nxt;
  logic [NREQ-1:0]        ack_q, ack_d, done_q, done_d, ctrl_q, ctrl_d, elig;
  logic                   win_vld, tgt_vld, tgt, grant;
  logic [OW-1:0]          win;
  logic [LENW-1:0]        win_len;
  logic                   lo0, lo1;

  assign elig = req & ~ack_q;

  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (elig[i]) begin
        win_vld = 1'b1;
        win     = OW'(i);
      end
    end
  end

  assign win_len = req_len[win*LENW +: LENW];
  assign lo0     = v_owner[0] < win;
  assign lo1     = v_owner[1] < win;

  // Retrigger own voice, else lowest free voice, else preempt a lower-priority owner.
  always_comb begin
    tgt_vld = 1'b0;
    tgt     = 1'b0;
    if (v_busy[0] && v_owner[0] == win) begin
      tgt_vld = 1'b1;
      tgt     = 1'b0;
    end else if (v_busy[1] && v_owner[1] == win) begin
      tgt_vld = 1'b1;
      tgt     = 1'b1;
    end else if (!v_busy[0]) begin
      tgt_vld = 1'b1;
      tgt     = 1'b0;
    end else if (!v_busy[1]) begin
      tgt_vld = 1'b1;
      tgt     = 1'b1;
    end else if (lo0 && lo1) begin
      tgt_vld = 1'b1;
      tgt     = (v_owner[0] < v_owner[1]) ? 1'b0 : 1'b1;
    end else if (lo0 || lo1) begin
      tgt_vld = 1'b1;
      tgt     = lo1;
    end
  end

  assign grant = win_vld && tgt_vld;

  always_comb begin
    ack_d  = '0;
    v_load = '0;
    if (grant) begin
      ack_d[win] = 1'b1;
      // Zero-length grants are acknowledged but leave the voices alone.
      if (win_len != '0) v_load[tgt] = 1'b1;
    end
  end

  always_comb begin
    done_d = '0;
    ctrl_d = '0;
    for (int v = 0; v < NV; v++) begin
      if (v_expire[v])   done_d[v_owner[v]]     = 1'b1;
      if (v_busy_nxt[v]) ctrl_d[v_owner_nxt[v]] = 1'b1;
    end
  end

  for (genvar v = 0; v < NV; v++) begin : g_voice
    sfx_voice #(.LENW(LENW), .OW(OW)) u_voice (
      .clk         (clk),
      .rst_n       (rst_n),
      .strobe_i    (sample_strobe),
      .load_i      (v_load[v]),
      .owner_i     (win),
      .len_i       (win_len),
      .busy_o      (v_busy[v]),
      .owner_o     (v_owner[v]),
      .busy_nxt_o  (v_busy_nxt[v]),
      .owner_nxt_o (v_owner_nxt[v]),
      .expire_o    (v_expire[v])
    );
    assign voice_owner[v*OW +: OW] = v_owner[v];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= '0;
      done_q <= '0;
      ctrl_q <= '0;
    end else begin
      ack_q  <= ack_d;
      done_q <= done_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign ack          = ack_q;
  assign done         = done_q;
  assign control      = ctrl_q;
  assign voice_active = v_busy;
endmodule

// File: doc/sfx_scheduler.md
SFX_SCHEDULER -- requirements
Module: sfx_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters; index NREQ-1 has highest priority.
REQ-002 SHALL have parameter LENW, default 12, width of per-request duration in samples.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sample_strobe  input  1  one-cycle pulse per audio sample; the same strobe drives sound_gen.
REQ-006 SHALL have port req  input  NREQ  level request per requester; held until ack.
REQ-007 SHALL have port req_len  input  NREQ*LENW  duration for requester i at bits [i*LENW +: LENW].
REQ-008 SHALL have port ack  output  NREQ  one-cycle registered grant pulse.
REQ-009 SHALL have port done  output  NREQ  one-cycle pulse on natural expiry of requester's voice.
REQ-010 SHALL have port voice_active  output  2  voice v busy.
REQ-011 SHALL have port voice_owner  output  4  owner index of voice v at bits [2v +: 2].
REQ-012 SHALL have port control  output  NREQ  bit i high iff a busy voice is owned by requester i; feeds the sound_gen tone enables.

Function
REQ-013 SHALL hold two voices, each with busy flag, owner index and LENW-bit remaining counter.
REQ-014 SHALL evaluate every clk cycle (not gated by sample_strobe); at most one grant per cycle.
REQ-015 SHALL mask requester i from arbitration in the cycle its ack is high.
REQ-016 SHALL select the highest-index eligible requester as winner.
REQ-017 Winner already owns a busy voice: SHALL retrigger that voice (reload remaining, owner unchanged).
REQ-018 Else a voice is free: SHALL allocate the lowest-index free voice.
REQ-019 Else both busy: SHALL preempt the voice whose owner has lower priority than winner; if both lower, preempt the lower-priority owner; if both owners equal priority, preempt voice 1.
REQ-020 Else (winner priority below both owners): no grant, no ack; request stays pending.
REQ-021 On grant, SHALL pulse ack[winner] in the cycle after the edge at which req was sampled, and load remaining=req_len of the winner at that same edge.
REQ-022 Grant with req_len==0: SHALL ack, allocate no voice, pulse no done.
REQ-023 On each sample_strobe, SHALL decrement remaining of every busy voice not being granted at that edge.
REQ-024 Remaining 1->0 on strobe: SHALL clear busy and pulse done[owner] the following cycle.
REQ-025 Grant targeting a voice expiring at the same edge: grant wins; no done pulse.
REQ-026 Preempted or retriggered voice: SHALL NOT pulse done.
REQ-027 Voice expiring at an edge SHALL NOT count as free for arbitration until the next cycle.
REQ-028 control, voice_active, voice_owner SHALL be registered, consistent with voice state after each edge.
REQ-029 Both voices expiring on the same owner cannot occur (REQ-017); done bits of distinct owners MAY pulse together.

Reset
REQ-030 rst_n low SHALL immediately clear ack, done, control, voice_active, voice_owner, all busy flags and counters to 0.
REQ-031 Reset mid-playback SHALL drop all voices without done pulses; pending req re-arbitrated after rst_n rises.
REQ-032 First grant SHALL occur no earlier than the first rising clk edge after rst_n deasserts.

Verification
REQ-033 req[0]=1, len=3, strobe every 4 clks -> ack[0] 1 cycle later, voice 0 owner 0, control=0001; done[0] after 3rd strobe, control=0000.
REQ-034 req[1] and req[2] raised in the same cycle, both len=10 -> ack[2] first (voice 0), ack[1] next cycle (voice 1); control=0110.
REQ-035 Voices owned by 0 and 1, req[3] len=5 -> voice with owner 0 preempted, owner 3; no done[0]; control=1010.
REQ-036 Voices owned by 2 and 3, req[1] -> no ack while both busy; ack[1] the cycle after first voice expires.
REQ-037 Voice 0 owner 2 remaining=1, req[2] len=8 at strobe edge -> retrigger, remaining=8, no done[2], voice 1 untouched.
REQ-038 rst_n pulsed low while both voices busy -> all outputs 0 asynchronously, no done pulses after release.
